// File: rtl/sge_share_pkg.sv
// Shared types and helpers for the signed greater-or-equal compare arbiter.
package sge_share_pkg;

    // Transaction phases: accept a request, compute the compare, present the result
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } state_e;

    // Widest requester vector the round-robin helper can scan
    localparam int MAX_NREQ = 8;

    // First valid requester at or above ptr, wrapping modulo nreq.
    // Returns 0 when nothing is valid; callers qualify with an any-valid flag.
    function automatic int rr_pick(input logic [MAX_NREQ-1:0] valid,
                                   input int ptr,
                                   input int nreq);
        int   pick;
        int   idx;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            idx = ptr + i;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end else begin
                idx = idx;
            end
            if ((i < nreq) && !found && valid[idx[2:0]]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sge_share_arbiter_if.sv
// Request/response bundle between client FSMs and the shared compare arbiter.
interface sge_share_arbiter_if #(
    parameter int WIDTH = 2,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       REQ_VALID;
    logic [NREQ-1:0]       REQ_READY;
    logic [NREQ*WIDTH-1:0] REQ_I0;
    logic [NREQ*WIDTH-1:0] REQ_I1;
    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic [IDW-1:0]        RSP_ID;
    logic                  RSP_GE;

    modport master (
        output REQ_VALID, REQ_I0, REQ_I1, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_ID, RSP_GE
    );

    modport slave (
        input  REQ_VALID, REQ_I0, REQ_I1, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_ID, RSP_GE
    );
endinterface

// File: rtl/sge_core.sv
// Combinational signed I0 >= I1: subtract via inverter and carry-in, then fix up
// the sign when the operands have different signs so overflow cannot flip the result.
module sge_core #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    output logic             O
);
    logic d_msb_s;

    // Sign of I0 - I1, with the operand-sign fix-up selecting the answer on mixed signs
    always_comb begin
        d_msb_s = 1'((I0 + ~I1 + {{(WIDTH-1){1'b0}}, 1'b1}) >> (WIDTH - 1));
        if (I0[WIDTH-1] != I1[WIDTH-1]) begin
            O = ~I0[WIDTH-1];
        end else begin
            O = ~d_msb_s;
        end
    end
endmodule

// File: rtl/sge_share_arbiter.sv
// Round-robin arbiter sharing one signed >= comparator among NREQ requesters.
// One compare is in flight at a time; the result returns tagged with the requester id.
module sge_share_arbiter
    import sge_share_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int NREQ  = 4
) (
    input  logic               CLK,
    input  logic               ASYNCRESETN,
    sge_share_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    state_e              state_r;
    state_e              next_state_s;
    logic [IDW-1:0]      rr_ptr_r;
    logic [IDW-1:0]      id_r;
    logic [IDW-1:0]      grant_s;
    logic [IDW-1:0]      grant_inc_s;
    logic [WIDTH-1:0]    op0_r;
    logic [WIDTH-1:0]    op1_r;
    logic [WIDTH-1:0]    grant_i0_s;
    logic [WIDTH-1:0]    grant_i1_s;
    logic [MAX_NREQ-1:0] valid_ext_s;
    logic [NREQ-1:0]     req_ready_s;
    logic                any_valid_s;
    logic                accept_s;
    logic                ge_s;
    logic                rsp_valid_r;
    logic [IDW-1:0]      rsp_id_r;
    logic                rsp_ge_r;

    // Pick the round-robin winner and steer its operands
    always_comb begin
        valid_ext_s           = '0;
        valid_ext_s[NREQ-1:0] = bus.REQ_VALID;
        any_valid_s           = |bus.REQ_VALID;
        grant_s               = IDW'(rr_pick(valid_ext_s, int'(rr_ptr_r), NREQ));
        if (grant_s == IDW'(NREQ - 1)) begin
            grant_inc_s = '0;
        end else begin
            grant_inc_s = grant_s + IDW'(1);
        end
        grant_i0_s = bus.REQ_I0[grant_s*WIDTH +: WIDTH];
        grant_i1_s = bus.REQ_I1[grant_s*WIDTH +: WIDTH];
    end

    // Next-state logic; a grant is offered only while idle
    always_comb begin
        next_state_s = state_r;
        req_ready_s  = '0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    req_ready_s[grant_s] = 1'b1;
                    accept_s             = 1'b1;
                    next_state_s         = COMPARE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            COMPARE: begin
                next_state_s = RESPOND;
            end
            RESPOND: begin
                if (bus.RSP_READY) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESPOND;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the granted operands and id, and move the pointer past the winner
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            rr_ptr_r <= '0;
            id_r     <= '0;
            op0_r    <= '0;
            op1_r    <= '0;
        end else if (accept_s) begin
            rr_ptr_r <= grant_inc_s;
            id_r     <= grant_s;
            op0_r    <= grant_i0_s;
            op1_r    <= grant_i1_s;
        end
    end

    sge_core #(.WIDTH(WIDTH)) u_core (
        .I0 (op0_r),
        .I1 (op1_r),
        .O  (ge_s)
    );

    // Response registers, held stable while the consumer back-pressures
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_ge_r    <= 1'b0;
        end else if (state_r == COMPARE) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
            rsp_ge_r    <= ge_s;
        end else if ((state_r == RESPOND) && bus.RSP_READY) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign bus.REQ_READY = req_ready_s;
    assign bus.RSP_VALID = rsp_valid_r;
    assign bus.RSP_ID    = rsp_id_r;
    assign bus.RSP_GE    = rsp_ge_r;
endmodule

// File: tb/tb_sge_share_arbiter.sv
// Bench for sge_share_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level reference model of grant order and timing.
module tb_sge_share_arbiter;
    localparam int WIDTH = 2;
    localparam int NREQ  = 4;
    localparam int IDW   = $clog2(NREQ);
    localparam int WB    = 8;

    logic CLK         = 1'b0;
    logic ASYNCRESETN = 1'b1;
    always #5 CLK = ~CLK;

    sge_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus_a ();
    sge_share_arbiter_if #(.WIDTH(WB),    .NREQ(NREQ)) bus_b ();

    sge_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut_a (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(bus_a.slave));
    sge_share_arbiter #(.WIDTH(WB), .NREQ(NREQ)) dut_b (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(bus_b.slave));

    int n_checks;
    int n_errors;

    // Requester-side stimulus for DUT A
    logic [NREQ-1:0]  valid_v;
    logic [WIDTH-1:0] i0_v [NREQ];
    logic [WIDTH-1:0] i1_v [NREQ];
    logic             rsp_rdy;

    // Reference model: pointer, outstanding transaction, its result and visibility cycle
    int   cyc;
    int   m_ptr;
    bit   m_busy;
    int   m_rsp_from;
    int   m_id;
    bit   m_ge;

    // Last observed DUT A outputs and observed grant log
    logic [NREQ-1:0] obs_ready;
    logic            obs_rv;
    logic [IDW-1:0]  obs_id;
    logic            obs_ge;
    int              glog[$];
    int              gcyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sxw(input logic [31:0] v, input int w);
        if (v[w-1]) return int'(v) - (1 << w);
        else return int'(v);
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic apply_a();
        bus_a.REQ_VALID = valid_v;
        for (int k = 0; k < NREQ; k++) begin
            bus_a.REQ_I0[k*WIDTH +: WIDTH] = i0_v[k];
            bus_a.REQ_I1[k*WIDTH +: WIDTH] = i1_v[k];
        end
        bus_a.RSP_READY = rsp_rdy;
    endtask

    // One cycle of DUT A: drive, sample, compare with the model, advance past the edge
    task automatic step();
        int              g;
        logic [NREQ-1:0] exp_ready;
        logic            exp_rv;
        apply_a();
        #1;
        obs_ready = bus_a.REQ_READY;
        obs_rv    = bus_a.RSP_VALID;
        obs_id    = bus_a.RSP_ID;
        obs_ge    = bus_a.RSP_GE;
        g = m_busy ? -1 : pick(valid_v, m_ptr);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_rv = m_busy && (cyc >= m_rsp_from);
        check("req_ready", 32'(obs_ready), 32'(exp_ready));
        check("rsp_valid", 32'(obs_rv), 32'(exp_rv));
        if (exp_rv) begin
            check("rsp_id", 32'(obs_id), 32'(m_id));
            check("rsp_ge", 32'(obs_ge), 32'(m_ge));
        end
        for (int k = 0; k < NREQ; k++) begin
            if (obs_ready[k]) begin
                glog.push_back(k);
                gcyc.push_back(cyc);
            end
        end
        if (g >= 0) begin
            m_busy     = 1'b1;
            m_rsp_from = cyc + 2;
            m_id       = g;
            m_ge       = (sxw(32'(i0_v[g]), WIDTH) >= sxw(32'(i1_v[g]), WIDTH));
            m_ptr      = (g + 1) % NREQ;
        end else if (exp_rv && rsp_rdy) begin
            m_busy = 1'b0;
        end
        valid_v = valid_v & ~obs_ready;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        ASYNCRESETN = 1'b0;
        valid_v     = '0;
        apply_a();
        #1;
        check("rst_rsp_valid", 32'(bus_a.RSP_VALID), 32'd0);
        check("rst_req_ready", 32'(bus_a.REQ_READY), 32'd0);
        check("rst_rsp_id",    32'(bus_a.RSP_ID),    32'd0);
        check("rst_rsp_ge",    32'(bus_a.RSP_GE),    32'd0);
        repeat (2) @(posedge CLK);
        #3;
        ASYNCRESETN = 1'b1;
        m_ptr  = 0;
        m_busy = 1'b0;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drain(input int n);
        valid_v = '0;
        rsp_rdy = 1'b1;
        repeat (n) step();
    endtask

    // One compare through DUT B (WIDTH=8), requester 0, bounded wait for the response
    task automatic b_run(input logic [WB-1:0] a, input logic [WB-1:0] b);
        bit got;
        bit dropit;
        got = 1'b0;
        bus_b.REQ_VALID          = 4'b0001;
        bus_b.REQ_I0[WB-1:0]     = a;
        bus_b.REQ_I1[WB-1:0]     = b;
        bus_b.RSP_READY          = 1'b1;
        for (int w = 0; w < 10 && !got; w++) begin
            #1;
            if (bus_b.RSP_VALID) begin
                got = 1'b1;
                check("b_rsp_id", 32'(bus_b.RSP_ID), 32'd0);
                check("b_rsp_ge", 32'(bus_b.RSP_GE),
                      32'((sxw(32'(a), WB) >= sxw(32'(b), WB)) ? 1 : 0));
            end
            dropit = bus_b.REQ_READY[0];
            @(posedge CLK);
            #1;
            if (dropit) bus_b.REQ_VALID = '0;
        end
        if (!got) check("b_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit got;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        m_ptr    = 0;
        m_busy   = 1'b0;
        m_rsp_from = 0;
        m_id     = 0;
        m_ge     = 1'b0;
        rsp_rdy  = 1'b1;
        valid_v  = '0;
        for (int k = 0; k < NREQ; k++) begin
            i0_v[k] = '0;
            i1_v[k] = '0;
        end
        bus_b.REQ_VALID = '0;
        bus_b.REQ_I0    = '0;
        bus_b.REQ_I1    = '0;
        bus_b.RSP_READY = 1'b1;
        #2;
        do_reset();

        // Single request: +1 >= -2, response two cycles after the grant
        valid_v = 4'b0001; i0_v[0] = 2'b01; i1_v[0] = 2'b10;
        step();
        check("t1_ready", 32'(obs_ready), 32'd1);
        step();
        check("t1_compare_rv", 32'(obs_rv), 32'd0);
        step();
        check("t1_rv", 32'(obs_rv), 32'd1);
        check("t1_id", 32'(obs_id), 32'd0);
        check("t1_ge", 32'(obs_ge), 32'd1);
        drain(2);

        // Reset during COMPARE clears the response path without a clock edge
        valid_v = 4'b0001;
        step();
        ASYNCRESETN = 1'b0;
        #1;
        check("rst_cmp_rv", 32'(bus_a.RSP_VALID), 32'd0);
        do_reset();
        valid_v = 4'b1111;
        step();
        check("rst_ptr_zero", 32'(obs_ready), 32'd1);
        valid_v = '0;
        step();
        check("pre_rst_rv", 32'(bus_a.RSP_VALID), 32'd1);
        ASYNCRESETN = 1'b0;
        #1;
        check("rst_rsp_rv", 32'(bus_a.RSP_VALID), 32'd0);
        do_reset();
        drain(4);

        // Round robin with everyone requesting: 0,1,2,3,0 every 3 cycles
        glog.delete();
        gcyc.delete();
        rsp_rdy = 1'b1;
        for (int c = 0; c < 13; c++) begin
            valid_v = 4'b1111;
            step();
        end
        check("rr_count", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < glog.size()) begin
                check("rr_order",   32'(glog[i]), 32'(i % NREQ));
                check("rr_spacing", 32'(gcyc[i] - gcyc[0]), 32'(3 * i));
            end
        end
        drain(4);

        // Backpressure: response held, no grants, regrant one cycle after release
        valid_v = 4'b0010; i0_v[1] = 2'b11; i1_v[1] = 2'b00;
        rsp_rdy = 1'b0;
        repeat (3) step();
        check("bp_first_rv", 32'(obs_rv), 32'd1);
        valid_v = 4'b1101;
        repeat (5) begin
            step();
            check("bp_rv",    32'(obs_rv),    32'd1);
            check("bp_id",    32'(obs_id),    32'd1);
            check("bp_ge",    32'(obs_ge),    32'd0);
            check("bp_ready", 32'(obs_ready), 32'd0);
        end
        rsp_rdy = 1'b1;
        step();
        step();
        check("bp_regrant", 32'(obs_ready), 32'b0100);
        drain(4);

        // Exhaustive 2-bit compare through requester 2
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                valid_v = 4'b0100; i0_v[2] = 2'(a); i1_v[2] = 2'(b);
                rsp_rdy = 1'b1;
                got = 1'b0;
                for (int w = 0; w < 8 && !got; w++) begin
                    step();
                    if (obs_rv) begin
                        got = 1'b1;
                        check("ex_id", 32'(obs_id), 32'd2);
                        check("ex_ge", 32'(obs_ge),
                              32'((sxw(32'(a), WIDTH) >= sxw(32'(b), WIDTH)) ? 1 : 0));
                    end
                end
                if (!got) check("ex_timeout", 32'd0, 32'd1);
            end
        end

        // Sparse request set with the pointer at the top requester: wrap to 1, then 2
        valid_v = 4'b0110;
        i0_v[1] = 2'b10; i1_v[1] = 2'b01;
        i0_v[2] = 2'b01; i1_v[2] = 2'b01;
        step();
        check("sparse_first", 32'(obs_ready), 32'b0010);
        repeat (2) step();
        step();
        check("sparse_second", 32'(obs_ready), 32'b0100);
        drain(3);

        // Randomized traffic with drops and response backpressure
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!valid_v[k]) begin
                    if ($urandom_range(0, 99) < 35) begin
                        valid_v[k] = 1'b1;
                        i0_v[k]    = WIDTH'($urandom);
                        i1_v[k]    = WIDTH'($urandom);
                    end
                end else if ($urandom_range(0, 99) < 4) begin
                    valid_v[k] = 1'b0;
                end
            end
            rsp_rdy = ($urandom_range(0, 99) < 70);
            step();
        end
        drain(6);

        // Wide instance: extremes and random 8-bit operands
        b_run(8'h80, 8'h7F);
        b_run(8'h7F, 8'h80);
        b_run(8'h80, 8'h80);
        for (int r = 0; r < 8; r++) begin
            b_run(WB'($urandom), WB'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
